// File: rtl/mdc_unit_pkg.sv
// Shared opcode constants and word type for the MDC datapath and the MDM sequencer.
// Optional feature macro used by mdc_unit: MDC_MADD_EN.
`timescale 1ns/1ps
package mdc_unit_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MADD  = 3'b100
   } mdc_op_e;

   // MDM picks the 5-cycle path for multiply-class ops, 10 cycles otherwise.
   function automatic logic is_short_op(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD);
   endfunction

endpackage

// File: rtl/mdc_unit_divider.sv
// Combinational 32-bit signed/unsigned divider with defined divide-by-zero and overflow results.
`timescale 1ns/1ps
module mdc_divider
   import mdc_unit_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        is_signed,
   output logic [31:0] quot,
   output logic [31:0] rem
);

   logic signed [31:0] sq;
   logic signed [31:0] sr;

   always_comb begin
      sq   = '0;
      sr   = '0;
      quot = '1;
      rem  = a;
      if (b == '0) begin
         quot = '1;
         rem  = a;
      end else if (is_signed && (a == 32'h8000_0000) && (b == '1)) begin
         quot = 32'h8000_0000;
         rem  = '0;
      end else if (is_signed) begin
         sq   = $signed(a) / $signed(b);
         sr   = $signed(a) % $signed(b);
         quot = sq;
         rem  = sr;
      end else begin
         quot = a / b;
         rem  = a % b;
      end
   end

endmodule

// File: rtl/mdc_unit.sv
// Combinational multiply/divide datapath for the HI/LO unit, plus a registered divide-by-zero flag.
// Define MDC_MADD_EN to enable the madd opcode; otherwise 3'b100 passes HI/LO through.
`timescale 1ns/1ps
module mdc_unit
   import mdc_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   input  logic [2:0]  MDCCtrl,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [31:0] MDCResult_hi,
   output logic [31:0] MDCResult_lo,
   output logic        dz_flag
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   word_t       quot;
   word_t       rem;
   logic        div_signed;

   // Low 64 bits of a product of sign-extended operands equal the signed 32x32 product.
   assign prod_s = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
   assign prod_u = {32'b0, SrcA} * {32'b0, SrcB};

   assign div_signed = (MDCCtrl == OP_DIV);

   mdc_divider u_div (
      .a         (SrcA),
      .b         (SrcB),
      .is_signed (div_signed),
      .quot      (quot),
      .rem       (rem)
   );

`ifdef MDC_MADD_EN
   logic [63:0] acc;
   assign acc = {hi, lo} + prod_s;
`endif

   always_comb begin
      MDCResult_hi = hi;
      MDCResult_lo = lo;
      case (MDCCtrl)
         OP_MULT:  {MDCResult_hi, MDCResult_lo} = prod_s;
         OP_MULTU: {MDCResult_hi, MDCResult_lo} = prod_u;
         OP_DIV, OP_DIVU: begin
            MDCResult_hi = rem;
            MDCResult_lo = quot;
         end
`ifdef MDC_MADD_EN
         OP_MADD:  {MDCResult_hi, MDCResult_lo} = acc;
`endif
         default: begin
            MDCResult_hi = hi;
            MDCResult_lo = lo;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dz_flag <= 1'b0;
      end else begin
         dz_flag <= ((MDCCtrl == OP_DIV) || (MDCCtrl == OP_DIVU)) && (SrcB == '0);
      end
   end

endmodule

// File: tb/tb_mdc_unit.sv
// Directed-vector bench for mdc_unit with a queue scoreboard checked by an independent monitor.
`timescale 1ns/1ps
module tb_mdc_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] SrcA, SrcB, hi, lo;
   logic [2:0]  MDCCtrl;
   logic [31:0] MDCResult_hi, MDCResult_lo;
   logic        dz_flag;
   logic        vld = 1'b0;

   typedef struct {
      string       name;
      logic [31:0] ehi;
      logic [31:0] elo;
      logic        edz;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   mdc_unit dut (
      .clk          (clk),
      .reset        (reset),
      .SrcA         (SrcA),
      .SrcB         (SrcB),
      .MDCCtrl      (MDCCtrl),
      .hi           (hi),
      .lo           (lo),
      .MDCResult_hi (MDCResult_hi),
      .MDCResult_lo (MDCResult_lo),
      .dz_flag      (dz_flag)
   );

   // edz is the flag expected while this vector is presented, i.e. latched from the previous one.
   task automatic apply(input string name, input logic rst, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] h, input logic [31:0] l,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
      exp_t e;
      @(posedge clk);
      #1;
      reset   = rst;
      MDCCtrl = op;
      SrcA    = a;
      SrcB    = b;
      hi      = h;
      lo      = l;
      e.name = name;
      e.ehi  = ehi;
      e.elo  = elo;
      e.edz  = edz;
      exp_q.push_back(e);
      vld = 1'b1;
   endtask

   always @(negedge clk) begin
      if (vld) begin
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_underflow: output presented with no expectation queued");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (MDCResult_hi !== e.ehi) begin
               n_bad++;
               $display("FAIL %s hi: got %h expected %h", e.name, MDCResult_hi, e.ehi);
            end
            if (MDCResult_lo !== e.elo) begin
               n_bad++;
               $display("FAIL %s lo: got %h expected %h", e.name, MDCResult_lo, e.elo);
            end
            if (dz_flag !== e.edz) begin
               n_bad++;
               $display("FAIL %s dz_flag: got %b expected %b", e.name, dz_flag, e.edz);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; MDCCtrl = 3'b000; SrcA = '0; SrcB = '0; hi = '0; lo = '0;
      repeat (3) @(posedge clk);

      apply("rsv111_b0",  1'b0, 3'b111, 32'h0, 32'h0, 32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 1'b0);
      apply("mult_neg3x5", 1'b0, 3'b000, 32'hFFFFFFFD, 32'd5, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
      apply("multu_max2", 1'b0, 3'b001, 32'hFFFFFFFF, 32'd2, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFE, 1'b0);
      apply("div_neg7_2", 1'b0, 3'b010, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      apply("divu_big_2", 1'b0, 3'b011, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 32'h00000001, 32'h7FFFFFFC, 1'b0);
      apply("divu_by0",   1'b0, 3'b011, 32'd7, 32'd0, 32'h0, 32'h0, 32'h00000007, 32'hFFFFFFFF, 1'b0);
      apply("div_ovf",    1'b0, 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h00000000, 32'h80000000, 1'b1);
      apply("div_100_m7", 1'b0, 3'b010, 32'd100, 32'hFFFFFFF9, 32'h0, 32'h0, 32'h00000002, 32'hFFFFFFF2, 1'b0);
      apply("div_m100_7", 1'b0, 3'b010, 32'hFFFFFF9C, 32'd7, 32'h0, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0);
      apply("div_by0",    1'b0, 3'b010, 32'hFFFFFFF0, 32'd0, 32'h0, 32'h0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b0);
      apply("mult_min2",  1'b0, 3'b000, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h40000000, 32'h00000000, 1'b1);
      apply("multu_max2x",1'b0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 1'b0);
`ifdef MDC_MADD_EN
      apply("madd_carry", 1'b0, 3'b100, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
      apply("madd_neg",   1'b0, 3'b100, 32'hFFFFFFFF, 32'd6, 32'h0, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
`else
      apply("madd_off",   1'b0, 3'b100, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0);
      apply("madd_off2",  1'b0, 3'b100, 32'hFFFFFFFF, 32'd6, 32'h0, 32'd5, 32'h00000000, 32'h00000005, 1'b0);
`endif
      apply("rsv101",     1'b0, 3'b101, 32'd3, 32'd0, 32'hAAAA5555, 32'h0, 32'hAAAA5555, 32'h00000000, 1'b0);
      apply("divu_by0_b", 1'b0, 3'b011, 32'd7, 32'd0, 32'h0, 32'h0, 32'h00000007, 32'hFFFFFFFF, 1'b0);
      apply("rsv110_rst", 1'b1, 3'b110, 32'd1, 32'd0, 32'hCAFEF00D, 32'h01020304, 32'hCAFEF00D, 32'h01020304, 1'b1);
      apply("divu_after_rst", 1'b0, 3'b011, 32'd7, 32'd0, 32'h0, 32'h0, 32'h00000007, 32'hFFFFFFFF, 1'b0);
      apply("mult_3x4",   1'b0, 3'b000, 32'd3, 32'd4, 32'h0, 32'h0, 32'h00000000, 32'h0000000C, 1'b1);

      @(posedge clk);
      #1 vld = 1'b0;
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
